eab_burst_agu: RTL and testbench
================================

# eab_burst_agu

Parametrised, registered successor to the LC-3 effective-address adder. It forms base + sign-extended IR offset, with base selected from PC or Ra, and emits the result through a valid/ready output register. It can also expand one request into a burst of consecutive incrementing or decrementing addresses for multi-word load/store sequencing. It sits between the decode/control FSM and the MAR/PC-load paths.

## Interface
- WIDTH, 16, address/data width; must be ≥ 11
- BURST_W, 4, width of the burst-length field and the internal beat counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge
- ir  in  11  IR[10:0] offset source
- sel_eab2  in  2  offset select: 00 = zero, 01 = sext(ir[5:0]), 10 = sext(ir[8:0]), 11 = sext(ir[10:0])
- sel_eab1  in  1  base select: 0 = pc, 1 = ra
- pc  in  WIDTH  program counter
- ra  in  WIDTH  register-file base
- burst_len  in  BURST_W  extra beats after the first; 0 = single address
- burst_dec  in  1  0 = successive beats +1, 1 = successive beats −1
- out_valid  out  1  eab_out valid
- out_ready  in  1  consumer takes beat when out_valid && out_ready
- eab_out  out  WIDTH  current address
- out_last  out  1  current beat is final beat of request
- busy  out  1  high while state = BURST

## Operation
- Sign extension replicates the selected field's MSB (ir[5], ir[8] or ir[10]) to WIDTH bits. The zero select yields all-zero.
- first = base + offset, modulo 2^WIDTH. Carry is discarded, with no overflow flag.
- Request fields (ir, sel_*, pc, ra, burst_len, burst_dec) are sampled only at accept. They are don't-care otherwise.
- The FSM has three states: IDLE, SINGLE and BURST.
  - In IDLE, out_valid = 0.
  - SINGLE means one beat is pending (out_last = 1).
  - BURST means a beat is pending with remaining count > 0 (out_last = 0).
- Accept, from IDLE or on a final-beat handshake:
  - eab_out ← first
  - remaining ← burst_len
  - direction latched from burst_dec
  - next state is SINGLE if burst_len = 0, else BURST
- Beat handshake in BURST:
  - eab_out ← eab_out ± 1 (modulo 2^WIDTH)
  - remaining ← remaining − 1
  - go to SINGLE when remaining was 1
- Beat handshake in SINGLE: go to IDLE unless a new request is accepted in the same cycle.
- in_ready = (state = IDLE) || (state = SINGLE && out_ready). This gives back-to-back single requests at full throughput.
- Outputs: out_last = (state = SINGLE); out_valid = (state ≠ IDLE); busy = (state = BURST).
- Wrap-around: +1 from 2^WIDTH−1 gives 0, and −1 from 0 gives 2^WIDTH−1. The burst continues unaffected.

## Timing
- Reset values: state IDLE, out_valid 0, out_last 0, busy 0, eab_out 0, remaining 0. in_ready is 1 in the first cycle after reset is released.
- rst asserted mid-burst aborts the burst on that edge. Remaining beats are dropped and no out_last is produced.
- Latency: request accepted at edge N gives out_valid = 1 with eab_out = first after edge N (visible in cycle N+1). The combinational path is only pc/ra → adder → register.
- A burst of burst_len = L yields L+1 beats. With out_ready held high, one beat per cycle, last beat L cycles after the first.
- out_ready low stalls: eab_out, out_last and remaining hold, and out_valid stays high. Output never changes without a handshake.
- in_ready depends combinationally on out_ready in SINGLE only. No other combinational in→out path exists.
- Simultaneous final-beat handshake and new accept: the new first address is loaded on the same edge, with no bubble.

## Test plan
- Reset, then sel_eab1=0, pc=0x3000, sel_eab2=10, ir[8:0]=0x1FF, burst_len=0, out_ready=1 → next cycle out_valid=1, eab_out=0x2FFF, out_last=1; the following cycle out_valid=0.
- sel_eab1=1, ra=0x4000, sel_eab2=01, ir[5:0]=0x05, burst_len=3, burst_dec=0 → beats 0x4005, 0x4006, 0x4007, 0x4008 on consecutive cycles; out_last only on 0x4008; busy high for the first three beats.
- Same burst with out_ready toggling 1,0,0,1,… → eab_out/out_last hold during stalls; exactly 4 beats; in_ready=0 until the last beat handshakes.
- Wrap-around: pc=0xFFFE, sel_eab2=00, burst_len=3, burst_dec=0 → 0xFFFE, 0xFFFF, 0x0000, 0x0001. Then ra=0x0001, sel_eab1=1, sel_eab2=00, burst_dec=1, burst_len=2 → 0x0001, 0x0000, 0xFFFF.
- Back-to-back singles with in_valid and out_ready held high, pc = 0x10, 0x20, 0x30, sel_eab2=11, ir=0x7FF → eab_out 0x0F, 0x1F, 0x2F on consecutive cycles with no gaps.
- rst pulsed during the second beat of a burst_len=5 request → next cycle out_valid=0, eab_out=0, busy=0, in_ready=1. A new single request then completes normally.

Source files
------------

// File: rtl/eab_burst_agu.sv
// eab_burst_agu: registered LC-3 effective-address adder with burst expansion.
// Forms base (pc or ra) + sign-extended IR offset, presents it through a
// valid/ready output register, and optionally steps it +/-1 for extra beats.
module eab_burst_agu #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        ir,
  input  logic [1:0]         sel_eab2,
  input  logic               sel_eab1,
  input  logic [WIDTH-1:0]   pc,
  input  logic [WIDTH-1:0]   ra,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_dec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   eab_out,
  output logic               out_last,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_ADDR = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] ONE_CNT  = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t                    state_q;
  logic signed [WIDTH-1:0]   eab_q;
  logic        [BURST_W-1:0] remaining_q;
  logic                      dec_q;

  logic signed [WIDTH-1:0]   offset_d;
  logic signed [WIDTH-1:0]   base_d;
  logic signed [WIDTH-1:0]   first_d;
  logic                      accept;

  // Offset field selection with sign extension from the field's own MSB.
  function automatic logic signed [WIDTH-1:0] sext_offset(
    input logic [10:0] f,
    input logic [1:0]  sel
  );
    logic signed [WIDTH-1:0] v;
    v = '0;
    case (sel)
      2'b01:   v = {{(WIDTH-6){f[5]}},  f[5:0]};
      2'b10:   v = {{(WIDTH-9){f[8]}},  f[8:0]};
      2'b11:   v = {{(WIDTH-11){f[10]}}, f[10:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Next-beat address: one step in the latched direction, wrapping modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] step_addr(
    input logic signed [WIDTH-1:0] a,
    input logic                    dec
  );
    return dec ? (a - ONE_ADDR) : (a + ONE_ADDR);
  endfunction

  // Effective-address adder; carry out is intentionally discarded.
  always_comb begin
    offset_d = sext_offset(ir, sel_eab2);
    base_d   = sel_eab1 ? ra : pc;
    first_d  = base_d + offset_d;
  end

  // Handshake and status decode from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == SINGLE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state_q != IDLE);
    out_last  = (state_q == SINGLE);
    busy      = (state_q == BURST);
    eab_out   = eab_q;
  end

  // Control FSM with the output address and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      eab_q       <= '0;
      remaining_q <= '0;
      dec_q       <= 1'b0;
    end else if (accept) begin
      // New request: from IDLE, or overlapping the final-beat handshake.
      eab_q       <= first_d;
      remaining_q <= burst_len;
      dec_q       <= burst_dec;
      state_q     <= (burst_len == '0) ? SINGLE : BURST;
    end else begin
      case (state_q)
        BURST: begin
          if (out_ready) begin
            eab_q       <= step_addr(eab_q, dec_q);
            remaining_q <= remaining_q - ONE_CNT;
            if (remaining_q == ONE_CNT) state_q <= SINGLE;
          end
        end
        SINGLE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eab_burst_agu.sv
// Directed bench for eab_burst_agu: reset state, single, burst, stall,
// wrap-around, back-to-back singles and mid-burst reset.
module tb_eab_burst_agu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] ir;
  logic [1:0]  sel_eab2;
  logic        sel_eab1;
  logic [15:0] pc;
  logic [15:0] ra;
  logic [3:0]  burst_len;
  logic        burst_dec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] eab_out;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] e [8];

  eab_burst_agu #(.WIDTH(16), .BURST_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir        (ir),
    .sel_eab2  (sel_eab2),
    .sel_eab1  (sel_eab1),
    .pc        (pc),
    .ra        (ra),
    .burst_len (burst_len),
    .burst_dec (burst_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eab_out   (eab_out),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the request currently driven, then walk its beats against exp[].
  // With stall set, out_ready follows 1,0,0,1,0,0,...
  task automatic run_beats(input logic [15:0] exp [8], input int n, input bit stall);
    int idx;
    bit hs;
    idx = 0;
    tick();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < n; cyc++) begin
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      #1;
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_addr",  {16'd0, eab_out},   {16'd0, exp[idx]});
      chk("beat_last",  {31'd0, out_last},  {31'd0, idx == n - 1});
      chk("beat_busy",  {31'd0, busy},      {31'd0, idx != n - 1});
      chk("beat_inrdy", {31'd0, in_ready},  {31'd0, (idx == n - 1) && out_ready});
      hs = out_ready;
      tick();
      if (hs) idx++;
    end
    chk("beat_count", idx, n);
    out_ready = 1'b1;
    #1;
    chk("after_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ir = '0; sel_eab2 = '0; sel_eab1 = 1'b0;
    pc = '0; ra = '0; burst_len = '0; burst_dec = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_eab",   {16'd0, eab_out},   32'd0);
    rst = 1'b0;
    #1;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);

    // Single: pc + sext9(0x1FF) = 0x3000 - 1
    sel_eab1 = 1'b0; pc = 16'h3000; sel_eab2 = 2'b10; ir = 11'h1FF;
    burst_len = 4'd0; burst_dec = 1'b0; in_valid = 1'b1;
    e = '{0: 16'h2FFF, default: 16'h0};
    run_beats(e, 1, 1'b0);

    // Incrementing burst from ra + 5
    sel_eab1 = 1'b1; ra = 16'h4000; sel_eab2 = 2'b01; ir = 11'h005;
    burst_len = 4'd3; burst_dec = 1'b0; in_valid = 1'b1;
    e = '{0: 16'h4005, 1: 16'h4006, 2: 16'h4007, 3: 16'h4008, default: 16'h0};
    run_beats(e, 4, 1'b0);

    // Same burst under back-pressure
    in_valid = 1'b1;
    run_beats(e, 4, 1'b1);

    // Wrap-around upward
    sel_eab1 = 1'b0; pc = 16'hFFFE; sel_eab2 = 2'b00; ir = 11'h7FF;
    burst_len = 4'd3; burst_dec = 1'b0; in_valid = 1'b1;
    e = '{0: 16'hFFFE, 1: 16'hFFFF, 2: 16'h0000, 3: 16'h0001, default: 16'h0};
    run_beats(e, 4, 1'b0);

    // Wrap-around downward
    sel_eab1 = 1'b1; ra = 16'h0001; sel_eab2 = 2'b00;
    burst_len = 4'd2; burst_dec = 1'b1; in_valid = 1'b1;
    e = '{0: 16'h0001, 1: 16'h0000, 2: 16'hFFFF, default: 16'h0};
    run_beats(e, 3, 1'b0);

    // Back-to-back singles: pc + sext11(0x7FF) = pc - 1
    sel_eab1 = 1'b0; sel_eab2 = 2'b11; ir = 11'h7FF; burst_len = 4'd0;
    burst_dec = 1'b0; out_ready = 1'b1; pc = 16'h0010; in_valid = 1'b1;
    tick();
    chk("b2b_0_addr", {16'd0, eab_out}, 32'h000F);
    chk("b2b_0_last", {31'd0, out_last}, 32'd1);
    chk("b2b_0_rdy",  {31'd0, in_ready}, 32'd1);
    pc = 16'h0020;
    tick();
    chk("b2b_1_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_1_addr",  {16'd0, eab_out},   32'h001F);
    pc = 16'h0030;
    tick();
    chk("b2b_2_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_2_addr",  {16'd0, eab_out},   32'h002F);
    in_valid = 1'b0;
    tick();
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset during the second beat of a 6-beat burst
    sel_eab1 = 1'b0; pc = 16'h0100; sel_eab2 = 2'b00; burst_len = 4'd5;
    burst_dec = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort_b0", {16'd0, eab_out}, 32'h0100);
    tick();
    chk("abort_b1", {16'd0, eab_out}, 32'h0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_eab",   {16'd0, eab_out},   32'd0);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_last",  {31'd0, out_last},  32'd0);
    chk("abort_inrdy", {31'd0, in_ready},  32'd1);

    // Recovery single after the abort
    pc = 16'h1234; sel_eab2 = 2'b00; burst_len = 4'd0; in_valid = 1'b1;
    e = '{0: 16'h1234, default: 16'h0};
    run_beats(e, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
